// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, reset PC and FSM state encoding for the PC sequencer
package pc_seq_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;
endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: sequential fetch address, modulo 2^PC_W
module pc_incrementer
  import pc_seq_pkg::*;
#(
  parameter int PC_STEP = 4
) (
  input  logic [PC_W-1:0] pc_i,
  output logic [PC_W-1:0] pc_o
);
  always_comb pc_o = pc_i + PC_W'(PC_STEP);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, next-PC select, flush strobes and redirect counter
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              PC_STEP  = 4,
  parameter int              CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Jump,
  input  logic [PC_W-1:0]  JumpTarget,
  input  logic             BranchTaken,
  input  logic [PC_W-1:0]  BranchTarget,
  input  logic             Halt,
  output logic [PC_W-1:0]  PCResult,
  output logic [PC_W-1:0]  PCAddResult,
  output logic             FetchValid,
  output logic             FlushIF,
  output logic             FlushID,
  output logic             Error,
  output logic [CNT_W-1:0] RedirectCount
);
  state_e            state_q;
  logic [PC_W-1:0]   pc_q, pc_d, target;
  logic              fv_q, err_q, redirect, misaligned, run;
  logic [CNT_W-1:0]  cnt_q;
  pc_incrementer #(.PC_STEP(PC_STEP)) u_inc (
    .pc_i (pc_q),
    .pc_o (PCAddResult)
  );
  always_comb begin
    redirect   = BranchTaken || Jump;
    target     = BranchTaken ? BranchTarget : JumpTarget;
    misaligned = redirect && (target[1:0] != 2'b00);
    run        = state_q == S_RUN;
    FlushIF    = !Reset && run && redirect;
    FlushID    = !Reset && run && BranchTaken;
    pc_d       = !run || misaligned ? pc_q :
                 redirect           ? target :
                 Halt || Stall      ? pc_q : PCAddResult;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_BOOT: begin
          state_q <= S_RUN;
          fv_q    <= 1'b1;
        end
        S_RUN:
          if (misaligned) begin
            err_q   <= 1'b1;
            state_q <= S_HALT;
            fv_q    <= 1'b0;
          end else if (redirect) begin
            cnt_q <= cnt_q + CNT_W'(!(&cnt_q));
          end else if (Halt) begin
            state_q <= S_HALT;
            fv_q    <= 1'b0;
          end
        default: ;
      endcase
    end
  end
  always_comb begin
    PCResult      = pc_q;
    FetchValid    = fv_q;
    Error         = err_q;
    RedirectCount = cnt_q;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a behavioural model
module tb_pc_sequencer;
  localparam int CW = 4;
  logic          Clk = 1'b0;
  logic          Reset, Stall, Jump, BranchTaken, Halt;
  logic [31:0]   JumpTarget, BranchTarget;
  logic [31:0]   PCResult, PCAddResult;
  logic          FetchValid, FlushIF, FlushID, Error;
  logic [CW-1:0] RedirectCount;
  int vectors = 0;
  int miscompares = 0;
  int          m_st;
  logic [31:0] m_pc;
  bit          m_fv, m_err;
  int          m_cnt;

  pc_sequencer #(.CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .JumpTarget(JumpTarget),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Halt(Halt),
    .PCResult(PCResult), .PCAddResult(PCAddResult), .FetchValid(FetchValid),
    .FlushIF(FlushIF), .FlushID(FlushID), .Error(Error), .RedirectCount(RedirectCount)
  );

  always #5 Clk = ~Clk;

  // m_st: 0 boot, 1 run, 2 halted
  task automatic model_edge();
    logic [31:0] t;
    if (Reset) begin
      m_st = 0; m_pc = 0; m_fv = 0; m_err = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_fv = 1;
    end else if (m_st == 1) begin
      if (BranchTaken || Jump) begin
        t = BranchTaken ? BranchTarget : JumpTarget;
        if (t % 4 != 0) begin
          m_err = 1; m_st = 2; m_fv = 0;
        end else begin
          m_pc = t;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end else if (Halt) begin
        m_st = 2; m_fv = 0;
      end else if (!Stall) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Reset = 0; Stall = 0; Jump = 0; BranchTaken = 0; Halt = 0;
    JumpTarget = 0; BranchTarget = 0;
  endtask

  task automatic do_reset();
    idle(); Reset = 1; step(); Reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    vectors++; if (PCResult !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp 0", PCResult); end
    vectors++; if (FetchValid !== 1'b0) begin miscompares++; $display("FAIL reset_fv got %b exp 0", FetchValid); end
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b exp 0", Error); end
    vectors++; if (RedirectCount !== '0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", RedirectCount); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++; if (PCResult !== exp_pc[i]) begin miscompares++; $display("FAIL boot_pc[%0d] got %h exp %h", i, PCResult, exp_pc[i]); end
      vectors++; if (FetchValid !== 1'b1) begin miscompares++; $display("FAIL boot_fv[%0d] got %b exp 1", i, FetchValid); end
    end
  endtask

  task automatic test_stall();
    step();
    vectors++; if (PCResult !== 32'h10) begin miscompares++; $display("FAIL stall_pre got %h exp 10", PCResult); end
    Stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++; if (PCResult !== 32'h10) begin miscompares++; $display("FAIL stall_hold[%0d] got %h exp 10", i, PCResult); end
      vectors++; if (FetchValid !== 1'b1) begin miscompares++; $display("FAIL stall_fv[%0d] got %b exp 1", i, FetchValid); end
    end
    Stall = 0; step();
    vectors++; if (PCResult !== 32'h14) begin miscompares++; $display("FAIL stall_release got %h exp 14", PCResult); end
    vectors++; if (PCAddResult !== 32'h18) begin miscompares++; $display("FAIL pc_add got %h exp 18", PCAddResult); end
  endtask

  task automatic test_jump();
    for (int i = 0; i < 3; i++) step();
    vectors++; if (PCResult !== 32'h20) begin miscompares++; $display("FAIL jump_pre got %h exp 20", PCResult); end
    Jump = 1; JumpTarget = 32'h40; #1;
    vectors++; if (FlushIF !== 1'b1) begin miscompares++; $display("FAIL jump_flushif got %b exp 1", FlushIF); end
    vectors++; if (FlushID !== 1'b0) begin miscompares++; $display("FAIL jump_flushid got %b exp 0", FlushID); end
    step(); idle();
    vectors++; if (PCResult !== 32'h40) begin miscompares++; $display("FAIL jump_pc got %h exp 40", PCResult); end
    vectors++; if (RedirectCount !== CW'(1)) begin miscompares++; $display("FAIL jump_cnt got %0d exp 1", RedirectCount); end
  endtask

  task automatic test_branch_priority();
    BranchTaken = 1; BranchTarget = 32'h80; Jump = 1; JumpTarget = 32'h40; Stall = 1; #1;
    vectors++; if (FlushIF !== 1'b1) begin miscompares++; $display("FAIL br_flushif got %b exp 1", FlushIF); end
    vectors++; if (FlushID !== 1'b1) begin miscompares++; $display("FAIL br_flushid got %b exp 1", FlushID); end
    step(); idle();
    vectors++; if (PCResult !== 32'h80) begin miscompares++; $display("FAIL br_pc got %h exp 80", PCResult); end
    vectors++; if (RedirectCount !== CW'(2)) begin miscompares++; $display("FAIL br_cnt got %0d exp 2", RedirectCount); end
  endtask

  task automatic test_halt();
    Halt = 1; Jump = 1; JumpTarget = 32'h30;
    step(); idle();
    vectors++; if (PCResult !== 32'h30) begin miscompares++; $display("FAIL halt_jump_pc got %h exp 30", PCResult); end
    vectors++; if (FetchValid !== 1'b1) begin miscompares++; $display("FAIL halt_jump_fv got %b exp 1", FetchValid); end
    Halt = 1; step(); idle();
    vectors++; if (PCResult !== 32'h30) begin miscompares++; $display("FAIL halt_pc got %h exp 30", PCResult); end
    vectors++; if (FetchValid !== 1'b0) begin miscompares++; $display("FAIL halt_fv got %b exp 0", FetchValid); end
    Jump = 1; JumpTarget = 32'h100; #1;
    vectors++; if (FlushIF !== 1'b0) begin miscompares++; $display("FAIL halt_flushif got %b exp 0", FlushIF); end
    step(); step(); idle();
    vectors++; if (PCResult !== 32'h30) begin miscompares++; $display("FAIL halt_ignore_pc got %h exp 30", PCResult); end
    vectors++; if (RedirectCount !== CW'(3)) begin miscompares++; $display("FAIL halt_cnt got %0d exp 3", RedirectCount); end
  endtask

  task automatic test_misalign();
    do_reset(); step();
    Jump = 1; JumpTarget = 32'h42; #1;
    vectors++; if (FlushIF !== 1'b1) begin miscompares++; $display("FAIL mis_flushif got %b exp 1", FlushIF); end
    step(); idle(); step();
    vectors++; if (Error !== 1'b1) begin miscompares++; $display("FAIL mis_err got %b exp 1", Error); end
    vectors++; if (PCResult !== 32'h0) begin miscompares++; $display("FAIL mis_pc got %h exp 0", PCResult); end
    vectors++; if (FetchValid !== 1'b0) begin miscompares++; $display("FAIL mis_fv got %b exp 0", FetchValid); end
    vectors++; if (RedirectCount !== CW'(0)) begin miscompares++; $display("FAIL mis_cnt got %0d exp 0", RedirectCount); end
    do_reset();
    vectors++; if (Error !== 1'b0) begin miscompares++; $display("FAIL mis_reset_err got %b exp 0", Error); end
    step(); step();
    Reset = 1; BranchTaken = 1; BranchTarget = 32'h80; #1;
    vectors++; if (FlushIF !== 1'b0 || FlushID !== 1'b0) begin miscompares++; $display("FAIL reset_flush got %b%b exp 00", FlushIF, FlushID); end
    step(); idle();
    vectors++; if (PCResult !== 32'h0) begin miscompares++; $display("FAIL reset_mid_pc got %h exp 0", PCResult); end
  endtask

  task automatic test_wrap_saturate();
    step();
    Jump = 1; JumpTarget = 32'hFFFF_FFFC; step(); idle();
    vectors++; if (PCResult !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pre got %h exp fffffffc", PCResult); end
    vectors++; if (PCAddResult !== 32'h0) begin miscompares++; $display("FAIL wrap_add got %h exp 0", PCAddResult); end
    step();
    vectors++; if (PCResult !== 32'h0 || Error !== 1'b0) begin miscompares++; $display("FAIL wrap_pc got %h err %b exp 0 err 0", PCResult, Error); end
    for (int i = 0; i < 20; i++) begin
      BranchTaken = 1; BranchTarget = 32'h100 + 32'(i * 8); step();
    end
    idle();
    vectors++; if (RedirectCount !== {CW{1'b1}}) begin miscompares++; $display("FAIL sat_cnt got %0d exp %0d", RedirectCount, (1 << CW) - 1); end
  endtask

  task automatic test_random();
    bit exp_fif, exp_fid;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Reset        = $urandom_range(0, 99) < 2;
      BranchTaken  = $urandom_range(0, 99) < 15;
      Jump         = $urandom_range(0, 99) < 20;
      Stall        = $urandom_range(0, 99) < 25;
      Halt         = $urandom_range(0, 99) < 4;
      BranchTarget = {$urandom_range(0, 255), 2'b00} | ($urandom_range(0, 15) == 0 ? 32'h2 : 32'h0);
      JumpTarget   = {$urandom_range(0, 255), 2'b00} | ($urandom_range(0, 15) == 0 ? 32'h1 : 32'h0);
      #1;
      exp_fif = !Reset && m_st == 1 && (BranchTaken || Jump);
      exp_fid = !Reset && m_st == 1 && BranchTaken;
      vectors++; if (FlushIF !== exp_fif || FlushID !== exp_fid) begin miscompares++; $display("FAIL rnd_flush[%0d] got %b%b exp %b%b", i, FlushIF, FlushID, exp_fif, exp_fid); end
      step();
      vectors++; if (PCResult !== m_pc) begin miscompares++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, PCResult, m_pc); end
      vectors++; if (FetchValid !== m_fv || Error !== m_err) begin miscompares++; $display("FAIL rnd_fv_err[%0d] got %b%b exp %b%b", i, FetchValid, Error, m_fv, m_err); end
      vectors++; if (RedirectCount !== CW'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, RedirectCount, m_cnt); end
      vectors++; if (PCAddResult !== m_pc + 32'd4) begin miscompares++; $display("FAIL rnd_add[%0d] got %h exp %h", i, PCAddResult, m_pc + 32'd4); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_stall();
    test_jump();
    test_branch_priority();
    test_halt();
    test_misalign();
    test_wrap_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
